dm_hart_ctl: RTL and testbench
==============================

// Module: dm_hart_ctl
// PURPOSE
//  Debug Module (DM) side of debug_if: the initiator that drives halt_req, resume_req, command and exec
//  into the core's debug controller and consumes halted/done/write/bus/haltresume/exception.
//  Implements DMI registers dmcontrol (0x10), dmstatus (0x11), abstractcs (0x16), command (0x17) for one hart.
//  data0/progbuf storage lives in a separate block; this block only sequences halt/resume and abstract commands.
// PARAMETERS
//  PROGBUF_SIZE  2  reported in abstractcs.progbufsize[28:24]
//  DATA_COUNT    1  reported in abstractcs.datacount[3:0]
// PORTS
//  clk            in   1   clock, single domain
//  rst_n          in   1   reset, synchronous, active-low
//  reg_wr         in   1   DMI write strobe (1-cycle pulse)
//  reg_rd         in   1   DMI read strobe (1-cycle pulse); never asserted together with reg_wr
//  reg_addr       in   7   DMI register address
//  reg_wdata      in   32  DMI write data
//  reg_rdata      out  32  read data, valid the cycle after reg_rd
//  reg_rvalid     out  1   read data valid pulse
//  dm_active      out  1   dmcontrol.dmactive
//  halt_req       out  1   debug_if.halt_req, level
//  resume_req     out  1   debug_if.resume_req, level until ack
//  command        out  32  debug_if.command, stable while exec=1
//  exec           out  1   debug_if.exec, level until done
//  halted         in   1   debug_if.halted
//  done           in   1   debug_if.done, 1-cycle pulse
//  write          in   1   debug_if.write (data0 update; observed only for busy accounting, no effect here)
//  bus            in   1   debug_if.bus, qualified by done
//  haltresume     in   1   debug_if.haltresume, qualified by done
//  exception      in   1   debug_if.exception, qualified by done
// BEHAVIOUR
//  Reset (rst_n=0, or dmactive=0 after a write): all state 0. halt_req=resume_req=exec=0, command=0,
//   cmderr=0, resumeack=0, reg_rvalid=0, reg_rdata=0. While dmactive=0, writes are ignored except
//   dmcontrol.dmactive. Reset mid-command drops exec in the same cycle; a late done is ignored.
//  dmcontrol write: dmactive<=wdata[0]. haltreq<=wdata[31]. halt_req = haltreq && dmactive.
//   resumereq (wdata[30]) is accepted only when wdata[31]=0, halted=1, and FSM in IDLE. Otherwise it is
//   ignored (haltreq wins on simultaneous set). Accept: resumeack<=0, resume_req<=1.
//   Read: {haltreq,29'b0,ndm=0,dmactive}.
//  Resume handshake: resume_req holds until halted is sampled 0; that same edge sets resume_req<=0,
//   resumeack<=1.
//  dmstatus (read-only): [17:16]={2{resumeack}}, [11:10]={2{~halted}}, [9:8]={2{halted}},
//   [7]=authenticated=1, [3:0]=version=2, else 0.
//  abstractcs: read {3'b0,PROGBUF_SIZE[4:0],11'b0,busy,1'b0,cmderr[2:0],4'b0,DATA_COUNT[3:0]}.
//   Write while IDLE: cmderr <= cmderr & ~wdata[10:8] (W1C). Write while busy: cmderr<=1 if cmderr==0.
//  cmderr codes: 0 none, 1 busy, 2 notsupported, 3 exception, 4 haltresume, 5 bus.
//   Only set when 0; sticky until W1C.
//  FSM IDLE -> EXEC -> IDLE. busy = (state==EXEC).
//   IDLE, command write:
//    cmderr!=0: ignored, command unchanged.
//    cmdtype=wdata[31:24]; cmdtype>2: cmderr<=2.
//    cmdtype in {0,2} and halted=0: cmderr<=4.
//    Otherwise command<=wdata, exec<=1 next cycle, ->EXEC.
//    quick access (1) is legal running or halted; the hart reports a halted-hart error via haltresume.
//   EXEC: exec=1, command frozen. Command write: cmderr<=1 if 0, command unchanged.
//    On done=1: exec<=0 and ->IDLE at the same edge.
//    cmderr<=3 if exception, else 5 if bus, else 4 if haltresume (priority in that order), only if cmderr==0.
//    done in IDLE is ignored.
//  Quick access: hart halts itself; resume_req is not driven by this block; resumeack is unaffected.
//  Reads: reg_rdata/reg_rvalid registered, latency 1. Unmapped addresses read 0; writes to them are ignored.
//   A read in the same cycle as a state update returns the pre-update value.
// TESTING
//  Halt: write dmcontrol=0x8000_0001 -> halt_req=1 next cycle; halted=1 -> dmstatus reads 0x0000_0382.
//  Resume: while halted, write dmcontrol=0x4000_0001 -> resume_req=1; drop halted -> resume_req=0 and
//   resumeack=1, so dmstatus=0x0003_0C82.
//  Access register: halted, write command=0x0022_1001 -> exec=1, abstractcs.busy=1; done pulse -> exec=0,
//   cmderr=0; done+exception -> cmderr=3; W1C 0x700 -> cmderr=0.
//  Errors: running, command=0x0022_1001 -> no exec, cmderr=4; cmdtype=3 -> cmderr=2; command during
//   EXEC -> cmderr=1, command held.
//  Quick access while running: command=0x0100_0000 -> exec=1; done+haltresume -> cmderr=4.
//  dmactive reset: write dmcontrol=0 mid-EXEC -> exec=0, halt_req=0, cmderr=0 same cycle; a later done
//   is ignored.

Source files
------------

// File: rtl/dm_hart_ctl.sv
// Debug Module hart controller: DMI dmcontrol/dmstatus/abstractcs/command registers for one hart,
// sequencing halt/resume requests and abstract command execution over debug_if.
module dm_hart_ctl #(
  parameter int unsigned PROGBUF_SIZE = 2,
  parameter int unsigned DATA_COUNT   = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        reg_wr,
  input  logic        reg_rd,
  input  logic [6:0]  reg_addr,
  input  logic [31:0] reg_wdata,
  output logic [31:0] reg_rdata,
  output logic        reg_rvalid,
  output logic        dm_active,
  output logic        halt_req,
  output logic        resume_req,
  output logic [31:0] command,
  output logic        exec,
  input  logic        halted,
  input  logic        done,
  input  logic        write,
  input  logic        bus,
  input  logic        haltresume,
  input  logic        exception
);

  localparam logic [6:0] ADDR_DMCONTROL  = 7'h10;
  localparam logic [6:0] ADDR_DMSTATUS   = 7'h11;
  localparam logic [6:0] ADDR_ABSTRACTCS = 7'h16;
  localparam logic [6:0] ADDR_COMMAND    = 7'h17;

  localparam logic [4:0] PB_SIZE = 5'(PROGBUF_SIZE);
  localparam logic [3:0] D_COUNT = 4'(DATA_COUNT);

  localparam logic [2:0] ERR_NONE     = 3'd0;
  localparam logic [2:0] ERR_BUSY     = 3'd1;
  localparam logic [2:0] ERR_NOTSUP   = 3'd2;
  localparam logic [2:0] ERR_EXC      = 3'd3;
  localparam logic [2:0] ERR_HALTRES  = 3'd4;
  localparam logic [2:0] ERR_BUS      = 3'd5;

  typedef enum logic {IDLE, EXEC} state_t;

  state_t      state, state_n;
  logic        busy;
  logic        haltreq;
  logic        resumeack;
  logic [2:0]  cmderr, cmderr_n;
  logic [31:0] rd_mux;
  logic [7:0]  cmdtype;
  logic        wr_ctl, clear, wr_cmd, wr_acs;
  logic        cmd_accept, resume_accept;

  // data0 updates are handled elsewhere; write is part of the interface only
  logic unused;
  assign unused = write;

  assign cmdtype = reg_wdata[31:24];
  assign wr_ctl  = reg_wr && (reg_addr == ADDR_DMCONTROL);
  assign clear   = wr_ctl && !reg_wdata[0];
  assign wr_cmd  = reg_wr && dm_active && (reg_addr == ADDR_COMMAND);
  assign wr_acs  = reg_wr && dm_active && (reg_addr == ADDR_ABSTRACTCS);

  // quick access (type 1) may start on a running hart; the hart itself reports that case
  assign cmd_accept = wr_cmd && (state == IDLE) && (cmderr == ERR_NONE) &&
                      ((cmdtype == 8'd1) || (((cmdtype == 8'd0) || (cmdtype == 8'd2)) && halted));

  assign resume_accept = wr_ctl && dm_active && reg_wdata[0] && reg_wdata[30] && !reg_wdata[31] &&
                         halted && (state == IDLE);

  assign halt_req = haltreq && dm_active;

  always_ff @(posedge clk) begin
    if (!rst_n || clear) state <= IDLE;
    else                 state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE: if (cmd_accept) state_n = EXEC;
      EXEC: if (done)       state_n = IDLE;
      default:              state_n = IDLE;
    endcase
  end

  always_comb begin
    exec = (state == EXEC);
    busy = (state == EXEC);
  end

  // error codes are only recorded into a clear cmderr and stay until written back to zero
  always_comb begin
    cmderr_n = cmderr;
    if (busy && done && (cmderr_n == ERR_NONE)) begin
      if (exception)       cmderr_n = ERR_EXC;
      else if (bus)        cmderr_n = ERR_BUS;
      else if (haltresume) cmderr_n = ERR_HALTRES;
    end
    if (wr_acs) begin
      if (!busy)                       cmderr_n = cmderr_n & ~reg_wdata[10:8];
      else if (cmderr_n == ERR_NONE)   cmderr_n = ERR_BUSY;
    end
    if (wr_cmd) begin
      if (busy) begin
        if (cmderr_n == ERR_NONE) cmderr_n = ERR_BUSY;
      end else if (cmderr == ERR_NONE) begin
        if (cmdtype > 8'd2)   cmderr_n = ERR_NOTSUP;
        else if (!cmd_accept) cmderr_n = ERR_HALTRES;
      end
    end
  end

  always_comb begin
    rd_mux = 32'h0;
    case (reg_addr)
      ADDR_DMCONTROL:  rd_mux = {haltreq, 29'b0, 1'b0, dm_active};
      ADDR_DMSTATUS:   rd_mux = {14'b0, {2{resumeack}}, 4'b0, {2{~halted}}, {2{halted}},
                                 1'b1, 3'b0, 4'd2};
      ADDR_ABSTRACTCS: rd_mux = {3'b0, PB_SIZE, 11'b0, busy, 1'b0, cmderr, 4'b0, D_COUNT};
      default:         rd_mux = 32'h0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      dm_active  <= 1'b0;
      haltreq    <= 1'b0;
      resume_req <= 1'b0;
      resumeack  <= 1'b0;
      cmderr     <= ERR_NONE;
      command    <= 32'h0;
      reg_rdata  <= 32'h0;
      reg_rvalid <= 1'b0;
    end else begin
      reg_rvalid <= reg_rd;
      if (reg_rd) reg_rdata <= rd_mux;
      cmderr <= cmderr_n;
      if (wr_ctl) begin
        dm_active <= 1'b1;
        if (dm_active) haltreq <= reg_wdata[31];
      end
      // resume_req is held until the hart is seen running again
      if (resume_accept) begin
        resume_req <= 1'b1;
        resumeack  <= 1'b0;
      end else if (resume_req && !halted) begin
        resume_req <= 1'b0;
        resumeack  <= 1'b1;
      end
      if (cmd_accept) command <= reg_wdata;
    end
  end

endmodule

// File: tb/tb_dm_hart_ctl.sv
// Directed self-checking bench for dm_hart_ctl: halt/resume handshake, abstract commands,
// error codes and dmactive reset, with hand-computed expected register values.
module tb_dm_hart_ctl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        reg_wr, reg_rd;
  logic [6:0]  reg_addr;
  logic [31:0] reg_wdata;
  logic [31:0] reg_rdata;
  logic        reg_rvalid;
  logic        dm_active, halt_req, resume_req, exec;
  logic [31:0] command;
  logic        halted, done, write, bus, haltresume, exception;

  int total = 0;
  int bad   = 0;

  dm_hart_ctl #(.PROGBUF_SIZE(2), .DATA_COUNT(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .reg_wr(reg_wr), .reg_rd(reg_rd), .reg_addr(reg_addr), .reg_wdata(reg_wdata),
    .reg_rdata(reg_rdata), .reg_rvalid(reg_rvalid),
    .dm_active(dm_active), .halt_req(halt_req), .resume_req(resume_req),
    .command(command), .exec(exec),
    .halted(halted), .done(done), .write(write), .bus(bus),
    .haltresume(haltresume), .exception(exception)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [6:0] addr, input logic [31:0] data);
    reg_wr = 1'b1; reg_addr = addr; reg_wdata = data;
    tick();
    reg_wr = 1'b0; reg_wdata = 32'h0;
  endtask

  task automatic rd_check(input string tag, input logic [6:0] addr, input logic [31:0] exp);
    reg_rd = 1'b1; reg_addr = addr;
    tick();
    reg_rd = 1'b0;
    check({tag, "_rvalid"}, {31'b0, reg_rvalid}, 32'h1);
    check(tag, reg_rdata, exp);
  endtask

  task automatic pulse_done(input logic e, input logic b, input logic h);
    done = 1'b1; exception = e; bus = b; haltresume = h;
    tick();
    done = 1'b0; exception = 1'b0; bus = 1'b0; haltresume = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; reg_wr = 1'b0; reg_rd = 1'b0; reg_addr = 7'h0; reg_wdata = 32'h0;
    halted = 1'b0; done = 1'b0; write = 1'b0; bus = 1'b0; haltresume = 1'b0; exception = 1'b0;
    tick(); tick();
    check("rst_halt_req", {31'b0, halt_req}, 32'h0);
    check("rst_exec", {31'b0, exec}, 32'h0);
    check("rst_resume_req", {31'b0, resume_req}, 32'h0);
    check("rst_command", command, 32'h0);
    check("rst_dm_active", {31'b0, dm_active}, 32'h0);
    check("rst_rvalid", {31'b0, reg_rvalid}, 32'h0);
    check("rst_rdata", reg_rdata, 32'h0);
    rst_n = 1'b1;
    tick();

    // inactive: only dmactive is taken from a dmcontrol write
    wr(7'h10, 32'h8000_0001);
    check("inact_halt_req", {31'b0, halt_req}, 32'h0);
    check("inact_dm_active", {31'b0, dm_active}, 32'h1);
    rd_check("dmcontrol_act", 7'h10, 32'h0000_0001);

    // halt
    wr(7'h10, 32'h8000_0001);
    check("halt_req", {31'b0, halt_req}, 32'h1);
    rd_check("dmcontrol_halt", 7'h10, 32'h8000_0001);
    halted = 1'b1;
    tick();
    rd_check("dmstatus_halted", 7'h11, 32'h0000_0382);

    // resume handshake
    wr(7'h10, 32'h4000_0001);
    check("resume_req_set", {31'b0, resume_req}, 32'h1);
    check("resume_halt_req", {31'b0, halt_req}, 32'h0);
    tick();
    check("resume_req_hold", {31'b0, resume_req}, 32'h1);
    halted = 1'b0;
    tick();
    check("resume_req_clr", {31'b0, resume_req}, 32'h0);
    rd_check("dmstatus_resumed", 7'h11, 32'h0003_0C82);

    // haltreq wins over a simultaneous resumereq
    wr(7'h10, 32'h8000_0001);
    halted = 1'b1;
    tick();
    wr(7'h10, 32'hC000_0001);
    check("haltwins_resume_req", {31'b0, resume_req}, 32'h0);
    check("haltwins_halt_req", {31'b0, halt_req}, 32'h1);
    rd_check("dmstatus_ack_kept", 7'h11, 32'h0003_0382);

    // access register, clean completion
    wr(7'h17, 32'h0022_1001);
    check("ar_exec", {31'b0, exec}, 32'h1);
    check("ar_command", command, 32'h0022_1001);
    rd_check("ar_busy", 7'h16, 32'h0200_1001);
    pulse_done(1'b0, 1'b0, 1'b0);
    check("ar_exec_done", {31'b0, exec}, 32'h0);
    rd_check("ar_cmderr0", 7'h16, 32'h0200_0001);

    // exception completion, then partial and full W1C
    wr(7'h17, 32'h0022_1001);
    pulse_done(1'b1, 1'b1, 1'b1);
    rd_check("ar_exc", 7'h16, 32'h0200_0301);
    wr(7'h16, 32'h0000_0100);
    rd_check("w1c_partial", 7'h16, 32'h0200_0201);
    wr(7'h16, 32'h0000_0700);
    rd_check("w1c_full", 7'h16, 32'h0200_0001);

    // command while busy
    wr(7'h17, 32'h0022_1001);
    wr(7'h17, 32'h0022_1002);
    check("busy_cmd_held", command, 32'h0022_1001);
    check("busy_exec", {31'b0, exec}, 32'h1);
    rd_check("busy_err", 7'h16, 32'h0200_1101);
    pulse_done(1'b1, 1'b0, 1'b0);
    rd_check("busy_err_sticky", 7'h16, 32'h0200_0101);
    wr(7'h16, 32'h0000_0700);

    // errors while running
    halted = 1'b0;
    tick();
    wr(7'h17, 32'h0022_1001);
    check("run_ar_noexec", {31'b0, exec}, 32'h0);
    rd_check("run_ar_err", 7'h16, 32'h0200_0401);
    wr(7'h16, 32'h0000_0700);
    wr(7'h17, 32'h0300_0000);
    rd_check("notsup_err", 7'h16, 32'h0200_0201);
    wr(7'h17, 32'h0100_0000);
    check("err_blocks_cmd", {31'b0, exec}, 32'h0);
    check("err_cmd_unchanged", command, 32'h0022_1001);
    wr(7'h16, 32'h0000_0700);

    // quick access while running
    wr(7'h17, 32'h0100_0000);
    check("qa_exec", {31'b0, exec}, 32'h1);
    check("qa_command", command, 32'h0100_0000);
    pulse_done(1'b0, 1'b0, 1'b1);
    check("qa_exec_done", {31'b0, exec}, 32'h0);
    check("qa_no_resume", {31'b0, resume_req}, 32'h0);
    rd_check("qa_haltres", 7'h16, 32'h0200_0401);
    wr(7'h16, 32'h0000_0700);
    wr(7'h17, 32'h0100_0000);
    pulse_done(1'b0, 1'b1, 1'b1);
    rd_check("qa_bus", 7'h16, 32'h0200_0501);
    wr(7'h16, 32'h0000_0700);

    // done while idle is ignored; unmapped address reads 0
    pulse_done(1'b1, 1'b0, 1'b0);
    rd_check("idle_done", 7'h16, 32'h0200_0001);
    rd_check("unmapped", 7'h12, 32'h0000_0000);

    // dmactive reset mid-command
    halted = 1'b1;
    wr(7'h10, 32'h8000_0001);
    wr(7'h17, 32'h0022_1001);
    wr(7'h17, 32'h0022_1001);
    check("pre_clr_exec", {31'b0, exec}, 32'h1);
    wr(7'h10, 32'h0000_0000);
    check("clr_exec", {31'b0, exec}, 32'h0);
    check("clr_halt_req", {31'b0, halt_req}, 32'h0);
    check("clr_command", command, 32'h0);
    check("clr_dm_active", {31'b0, dm_active}, 32'h0);
    rd_check("clr_abstractcs", 7'h16, 32'h0200_0001);
    pulse_done(1'b1, 1'b0, 1'b0);
    wr(7'h10, 32'h0000_0001);
    check("late_done_exec", {31'b0, exec}, 32'h0);
    rd_check("late_done_ignored", 7'h16, 32'h0200_0001);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
